// File: rtl/pipe_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding,
// segment-width helper and the configuration legality check.
package pipe_add_sub_pkg;

  // Operation select encoding for the sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of one carry-chain segment (one pipeline stage).
  function automatic int seg_width(input int width, input int seg);
    return width / seg;
  endfunction

  // True when the width/segment combination can be built: at least two
  // result bits, at least one stage, no more stages than bits, and every
  // stage the same width.
  function automatic bit seg_cfg_ok(input int width, input int seg);
    return (width >= 2) && (seg >= 1) && (seg <= width) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_sub_adder_segment.sv
// Combinational ripple slice used by every pipeline stage, built from
// the single-bit full adder. Also exposes the carry into its MSB so the
// top segment can form the signed-overflow flag.

// Single-bit full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// W-bit ripple-carry slice.
module adder_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  genvar gi;

  // Each bit keeps its own carry nets so the ripple chain is a chain of
  // distinct signals rather than a self-referencing vector.
  for (gi = 0; gi < W; gi++) begin : g_bit
    logic c_in;
    logic c_out;

    if (gi == 0) begin : g_first
      assign c_in = cin;
    end else begin : g_rest
      assign c_in = g_bit[gi-1].c_out;
    end

    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (c_in),
      .s    (s[gi]),
      .cout (c_out)
    );
  end

  assign cout  = g_bit[W-1].c_out;
  assign c_msb = g_bit[W-1].c_in;

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined adder/subtractor. The carry chain is cut into SEG equal
// segments, one per stage; stage k adds bits [k*W +: W] using the carry
// registered by stage k-1. Each stage has a valid bit and moves forward
// whenever the stage after it is empty or itself moving, so the block
// streams one op per cycle and stalls cleanly under backpressure.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int W = seg_width(WIDTH, SEG);

  if (!seg_cfg_ok(WIDTH, SEG)) begin : g_cfg_check
    $error("pipe_add_sub: need WIDTH >= 2, 1 <= SEG <= WIDTH and WIDTH %% SEG == 0");
  end

  genvar gi;

  // Per-stage token state. Operands travel whole; bits already consumed
  // are never read downstream and fall away in synthesis.
  logic [SEG-1:0]   valid_reg;
  logic [WIDTH-1:0] a_reg     [SEG];
  logic [WIDTH-1:0] b_reg     [SEG];
  logic [WIDTH-1:0] sum_reg   [SEG];
  logic             carry_reg [SEG];
  logic             ovf_reg;

  // Handshake / flow control.
  logic [SEG-1:0]   take;
  logic [SEG-1:0]   adv;
  logic [SEG-1:0]   load;

  // Operand conditioning at acceptance.
  logic [WIDTH-1:0] b_inv;
  logic             c_entry;

  // Per-stage next values feeding the registers.
  logic [WIDTH-1:0] a_next    [SEG];
  logic [WIDTH-1:0] b_next    [SEG];
  logic [WIDTH-1:0] sum_next  [SEG];
  logic [W-1:0]     seg_s     [SEG];
  logic             seg_cout  [SEG];
  logic             seg_cmsb  [SEG];

  // Subtract is a + ~b + ~cin: invert B and the entry carry once, up front.
  assign b_inv   = (sub == OP_SUB) ? ~b   : b;
  assign c_entry = (sub == OP_SUB) ? ~cin : cin;

  // Flow control, evaluated from the output end back to the input end.
  always_comb begin
    take = '0;
    adv  = '0;
    load = '0;
    load[0] = in_valid;
    for (int i = 1; i < SEG; i++) begin
      load[i] = valid_reg[i-1];
    end
    adv[SEG-1]  = valid_reg[SEG-1] & out_ready;
    take[SEG-1] = ~valid_reg[SEG-1] | adv[SEG-1];
    for (int i = SEG - 2; i >= 0; i--) begin
      adv[i]  = valid_reg[i] & take[i+1];
      take[i] = ~valid_reg[i] | adv[i];
    end
  end

  // One ripple slice per stage; stage 0 works straight off the inputs.
  for (gi = 0; gi < SEG; gi++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic [WIDTH-1:0] merged;
    logic             src_c;

    if (gi == 0) begin : g_head
      assign src_a   = a;
      assign src_b   = b_inv;
      assign src_sum = '0;
      assign src_c   = c_entry;
    end else begin : g_body
      assign src_a   = a_reg[gi-1];
      assign src_b   = b_reg[gi-1];
      assign src_sum = sum_reg[gi-1];
      assign src_c   = carry_reg[gi-1];
    end

    adder_segment #(
      .W (W)
    ) u_seg (
      .a     (src_a[gi*W +: W]),
      .b     (src_b[gi*W +: W]),
      .cin   (src_c),
      .s     (seg_s[gi]),
      .cout  (seg_cout[gi]),
      .c_msb (seg_cmsb[gi])
    );

    // Result bits from earlier stages pass through; this stage fills its slice.
    always_comb begin
      merged = src_sum;
      merged[gi*W +: W] = seg_s[gi];
    end

    assign a_next[gi]   = src_a;
    assign b_next[gi]   = src_b;
    assign sum_next[gi] = merged;
  end

  // Stage registers: a stage loads whenever it can take a token, and
  // keeps its payload (and therefore the visible outputs) when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < SEG; i++) begin
        a_reg[i]     <= '0;
        b_reg[i]     <= '0;
        sum_reg[i]   <= '0;
        carry_reg[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < SEG; i++) begin
        if (take[i]) begin
          valid_reg[i] <= load[i];
          if (load[i]) begin
            a_reg[i]     <= a_next[i];
            b_reg[i]     <= b_next[i];
            sum_reg[i]   <= sum_next[i];
            carry_reg[i] <= seg_cout[i];
          end
        end
      end
      // Signed overflow: carry into the MSB differs from carry out of it.
      if (take[SEG-1] && load[SEG-1]) begin
        ovf_reg <= seg_cout[SEG-1] ^ seg_cmsb[SEG-1];
      end
    end
  end

  assign in_ready  = take[0];
  assign out_valid = valid_reg[SEG-1];
  assign sum       = sum_reg[SEG-1];
  assign cout      = carry_reg[SEG-1];
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: a 16/4 instance for directed,
// streaming, backpressure and reset cases, a 4/4 instance driven
// exhaustively and an 8/1 instance driven randomly.
module tb_pipe_add_sub;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int XW    = 4;
  localparam int XS    = 4;
  localparam int YW    = 8;
  localparam int YS    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Main DUT signals
  logic             rst, in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  // 4/4 DUT signals
  logic             x_rst, x_in_valid, x_in_ready, x_sub, x_cin, x_out_valid, x_out_ready, x_cout, x_ovf;
  logic [XW-1:0]    x_a, x_b, x_sum;
  // 8/1 DUT signals
  logic             y_rst, y_in_valid, y_in_ready, y_sub, y_cin, y_out_valid, y_out_ready, y_cout, y_ovf;
  logic [YW-1:0]    y_a, y_b, y_sum;

  pipe_add_sub #(.WIDTH(WIDTH), .SEG(SEG)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_add_sub #(.WIDTH(XW), .SEG(XS)) u_dut_x (
    .clk(clk), .rst(x_rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a(x_a), .b(x_b), .sub(x_sub), .cin(x_cin),
    .out_valid(x_out_valid), .out_ready(x_out_ready),
    .sum(x_sum), .cout(x_cout), .ovf(x_ovf)
  );

  pipe_add_sub #(.WIDTH(YW), .SEG(YS)) u_dut_y (
    .clk(clk), .rst(y_rst), .in_valid(y_in_valid), .in_ready(y_in_ready),
    .a(y_a), .b(y_b), .sub(y_sub), .cin(y_cin),
    .out_valid(y_out_valid), .out_ready(y_out_ready),
    .sum(y_sum), .cout(y_cout), .ovf(y_ovf)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pack {ovf, cout, sum} into one value for whole-result comparison.
  function automatic longint pack(input longint s, input bit c, input bit o, input int w);
    return s | (longint'(c) << w) | (longint'(o) << (w + 1));
  endfunction

  // Reference: plain integer arithmetic. cout is the unsigned carry for add
  // and "no borrow" for subtract; ovf is the signed result leaving range.
  function automatic longint ref_model(input longint av, input longint bv,
                                       input bit sb, input bit cn, input int w);
    longint m, half, full, sa, sbv, sres;
    bit co, ov;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (av >= half) ? av - m : av;
    sbv  = (bv >= half) ? bv - m : bv;
    if (!sb) begin
      full = av + bv + longint'(cn);
      co   = (full >= m);
      sres = sa + sbv + longint'(cn);
    end else begin
      full = av - bv - longint'(cn);
      co   = (full >= 0);
      sres = sa - sbv - longint'(cn);
    end
    ov = (sres < -half) || (sres >= half);
    return pack(full & (m - 1), co, ov, w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main scoreboard ----------------
  longint exp_q[$];
  int     acc_q[$];
  int     n_in = 0;
  int     n_out = 0;
  bit     lat_check = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("main_unexpected_out", 1, 0);
        end else begin
          longint e;
          int t;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check_eq("main_result", pack(longint'(sum), cout, ovf, WIDTH), e);
          if (lat_check) check_eq("main_latency", cyc - t, SEG);
          $display("[main] out #%0d sum=%h cout=%b ovf=%b", n_out, sum, cout, ovf);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(longint'(a), longint'(b), sub, cin, WIDTH));
        acc_q.push_back(cyc);
        n_in++;
      end
    end
  end

  // ---------------- 4/4 scoreboard ----------------
  longint x_exp_q[$];
  int     x_acc_q[$];
  int     x_n_out = 0;
  bit     x_done = 1'b0;

  always @(negedge clk) begin
    if (!x_rst) begin
      if (x_out_valid && x_out_ready) begin
        if (x_exp_q.size() == 0) begin
          check_eq("x_unexpected_out", 1, 0);
        end else begin
          longint e;
          int t;
          e = x_exp_q.pop_front();
          t = x_acc_q.pop_front();
          check_eq("x_result", pack(longint'(x_sum), x_cout, x_ovf, XW), e);
          check_eq("x_latency", cyc - t, XS);
          $display("[x] out #%0d sum=%h cout=%b ovf=%b", x_n_out, x_sum, x_cout, x_ovf);
          x_n_out++;
        end
      end
      if (x_in_valid && x_in_ready) begin
        x_exp_q.push_back(ref_model(longint'(x_a), longint'(x_b), x_sub, x_cin, XW));
        x_acc_q.push_back(cyc);
      end
    end
  end

  // ---------------- 8/1 scoreboard ----------------
  longint y_exp_q[$];
  int     y_acc_q[$];
  int     y_n_in = 0;
  int     y_n_out = 0;
  bit     y_done = 1'b0;

  always @(negedge clk) begin
    if (!y_rst) begin
      if (y_out_valid && y_out_ready) begin
        if (y_exp_q.size() == 0) begin
          check_eq("y_unexpected_out", 1, 0);
        end else begin
          longint e;
          int t;
          e = y_exp_q.pop_front();
          t = y_acc_q.pop_front();
          check_eq("y_result", pack(longint'(y_sum), y_cout, y_ovf, YW), e);
          check_eq("y_latency", cyc - t, YS);
          $display("[y] out #%0d sum=%h cout=%b ovf=%b", y_n_out, y_sum, y_cout, y_ovf);
          y_n_out++;
        end
      end
      if (y_in_valid && y_in_ready) begin
        y_exp_q.push_back(ref_model(longint'(y_a), longint'(y_b), y_sub, y_cin, YW));
        y_acc_q.push_back(cyc);
        y_n_in++;
      end
    end
  end

  // One isolated op on the main DUT with out_ready high: checks latency
  // and the result against bench-supplied expectations.
  task automatic run_op(input string tag, input longint av, input longint bv,
                        input bit sb, input bit cn, input longint exp);
    int lat;
    a = WIDTH'(av);
    b = WIDTH'(bv);
    sub = sb;
    cin = cn;
    in_valid = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    sub = 1'($urandom);
    cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, SEG);
    check_eq({tag, "_sum"}, longint'(sum), exp & ((longint'(1) << WIDTH) - 1));
    check_eq({tag, "_cout"}, cout, (exp >> WIDTH) & 1);
    check_eq({tag, "_ovf"}, ovf, (exp >> (WIDTH + 1)) & 1);
    tick();
  endtask

  task automatic drive_random();
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    sub = 1'($urandom);
    cin = 1'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base_in, base_out, n, saw;
    longint held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", longint'(sum), 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // Directed cases
    out_ready = 1'b1;
    lat_check = 1'b1;
    run_op("add_wrap",   'hFFFF, 'h0001, 1'b0, 1'b0, pack('h0000, 1'b1, 1'b0, WIDTH));
    run_op("add_ovf",    'h7FFF, 'h0001, 1'b0, 1'b0, pack('h8000, 1'b0, 1'b1, WIDTH));
    run_op("sub_borrow", 'h0005, 'h0007, 1'b1, 1'b0, pack('hFFFE, 1'b0, 1'b0, WIDTH));
    run_op("sub_ovf",    'h8000, 'h0001, 1'b1, 1'b0, pack('h7FFF, 1'b1, 1'b1, WIDTH));
    run_op("sub_cin",    'h0010, 'h0003, 1'b1, 1'b1, pack('h000C, 1'b1, 1'b0, WIDTH));

    // Streaming: 100 back-to-back ops
    base_out = n_out;
    for (int i = 0; i < 100; i++) begin
      drive_random();
      in_valid = 1'b1;
      #1;
      check_eq("stream_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (SEG + 2) tick();
    check_eq("stream_count", n_out - base_out, 100);

    // Backpressure: fill until full
    lat_check = 1'b0;
    out_ready = 1'b0;
    base_in = n_in;
    for (int i = 0; i < 8; i++) begin
      drive_random();
      in_valid = 1'b1;
      tick();
    end
    check_eq("bp_accepted", n_in - base_in, SEG);
    check_eq("bp_in_ready_full", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    held = pack(longint'(sum), cout, ovf, WIDTH);
    repeat (3) begin
      drive_random();
      tick();
      check_eq("bp_hold_stable", pack(longint'(sum), cout, ovf, WIDTH), held);
      check_eq("bp_hold_valid", out_valid, 1);
    end

    // Release: accept and drain in the same cycle
    drive_random();
    out_ready = 1'b1;
    #1;
    check_eq("bp_simul_in_ready", in_ready, 1);
    base_in = n_in;
    base_out = n_out;
    tick();
    check_eq("bp_simul_in", n_in - base_in, 1);
    check_eq("bp_simul_out", n_out - base_out, 1);
    in_valid = 1'b0;
    n = 0;
    while (out_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq("bp_drain_done", out_valid, 0);
    check_eq("bp_drain_count", n_out - base_out, SEG + 1);

    // Reset with 3 ops in flight
    out_ready = 1'b0;
    base_out = n_out;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("mrst_out_valid", out_valid, 0);
    check_eq("mrst_sum", longint'(sum), 0);
    check_eq("mrst_cout", cout, 0);
    check_eq("mrst_ovf", ovf, 0);
    out_ready = 1'b1;
    saw = 0;
    repeat (8) begin
      tick();
      if (out_valid) saw++;
    end
    check_eq("mrst_no_stale", saw, 0);
    check_eq("mrst_no_output", n_out - base_out, 0);
    lat_check = 1'b1;
    run_op("post_rst", 'h1234, 'h4321, 1'b0, 1'b1, ref_model('h1234, 'h4321, 1'b0, 1'b1, WIDTH));

    // Wait for the other configurations
    n = 0;
    while (!(x_done && y_done) && n < 5000) begin
      tick();
      n++;
    end
    check_eq("aux_done", x_done && y_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- 4/4 exhaustive ----------------
  initial begin
    x_rst = 1'b1; x_in_valid = 1'b0; x_out_ready = 1'b1;
    x_a = '0; x_b = '0; x_sub = 1'b0; x_cin = 1'b0;
    repeat (2) tick();
    x_rst = 1'b0;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int sv = 0; sv < 2; sv++) begin
          for (int cv = 0; cv < 2; cv++) begin
            x_a = XW'(av);
            x_b = XW'(bv);
            x_sub = 1'(sv);
            x_cin = 1'(cv);
            x_in_valid = 1'b1;
            tick();
          end
        end
      end
    end
    x_in_valid = 1'b0;
    repeat (XS + 3) tick();
    check_eq("x_count", x_n_out, 1024);
    x_done = 1'b1;
  end

  // ---------------- 8/1 random with input gaps ----------------
  initial begin
    y_rst = 1'b1; y_in_valid = 1'b0; y_out_ready = 1'b1;
    y_a = '0; y_b = '0; y_sub = 1'b0; y_cin = 1'b0;
    repeat (2) tick();
    y_rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      y_a = YW'($urandom);
      y_b = YW'($urandom);
      y_sub = 1'($urandom);
      y_cin = 1'($urandom);
      y_in_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    y_in_valid = 1'b0;
    repeat (YS + 3) tick();
    check_eq("y_count", y_n_out, y_n_in);
    y_done = 1'b1;
  end

endmodule
